// File: rtl/assoc_cache.sv
// assoc_cache: two-way set-associative write-back write-allocate cache with per-set LRU and burst memory port
module assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int INDEX_W = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;
  state_t state, state_nx;
  logic [SETS-1:0] valid [2];
  logic [SETS-1:0] dirty [2];
  logic [SETS-1:0] lru;
  logic [TAG_W-1:0] tags [2][SETS];
  logic [DATA_W-1:0] line_data [2][SETS][WORDS];
  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFSET_W-1:0] off, beat, beat_nx;
  logic hit0, hit1, hit, lookup, miss_vic, vic, first_miss, ack, last, busy;
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign idx = cpu_addr[OFFSET_W +: INDEX_W];
  assign off = cpu_addr[OFFSET_W-1:0];
  assign hit0 = valid[0][idx] && tags[0][idx] == tag;
  assign hit1 = valid[1][idx] && tags[1][idx] == tag;
  assign hit = hit0 || hit1;
  assign lookup = state == IDLE && cpu_req;
  assign miss_vic = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign ack = mem_req && mem_ack;
  assign last = &beat;
  assign beat_nx = beat + OFFSET_W'(1);
  assign busy = state == WB || state == FILL;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cpu_req) state_nx = hit ? RESP : (valid[miss_vic][idx] && dirty[miss_vic][idx]) ? WB : FILL;
      RESP: state_nx = IDLE;
      WB: if (ack && last) state_nx = FILL;
      FILL: if (ack && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cpu_ready = state == RESP;
    cpu_hit = state == RESP && !first_miss;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru <= '0;
      first_miss <= 1'b0;
      vic <= 1'b0;
      beat <= '0;
      cpu_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (lookup && hit) begin
        lru[idx] <= !hit1;
        if (cpu_we) dirty[hit1][idx] <= 1'b1;
        else cpu_rdata <= line_data[hit1][idx][off];
      end
      if (lookup && !hit) begin
        first_miss <= 1'b1;
        vic <= miss_vic;
      end
      if (state == RESP) first_miss <= 1'b0;
      if (busy && !mem_req) begin
        mem_req <= 1'b1;
        mem_we <= state == WB;
        mem_addr <= {state == WB ? tags[vic][idx] : tag, idx, beat};
        mem_wdata <= line_data[vic][idx][beat];
      end
      if (ack) begin
        beat <= beat_nx;
        mem_req <= !last;
        mem_addr <= {mem_addr[ADDR_W-1:OFFSET_W], beat_nx};
        mem_wdata <= line_data[vic][idx][beat_nx];
        if (last) dirty[vic][idx] <= 1'b0;
        if (last && state == FILL) valid[vic][idx] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (lookup && hit && cpu_we) line_data[hit1][idx][off] <= cpu_wdata;
    if (state == FILL && ack) line_data[vic][idx][beat] <= mem_rdata;
    if (state == FILL && ack && last) tags[vic][idx] <= tag;
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed vectors, stall/reset sequences and random traffic against a flat-memory LRU model
module tb_assoc_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req = 1'b0;
  logic cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic cpu_ready, cpu_hit, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  always #5 clk = ~clk;
  assoc_cache dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;
  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic hit;
    int nwb;
    int nfill;
    int nbursts;
    logic [15:0] wb_base;
    logic [15:0] fill_base;
  } vec_t;
  logic [15:0] bmem [65536];
  logic [15:0] ref_mem [65536];
  int rec [16][2];
  int cnt [16];
  beat_t beats [$];
  vec_t vt [7];
  int checks = 0, failures = 0;
  int ack_delay = 1, bursts = 0, stable_err = 0, wait_cnt = 0;
  logic pend = 1'b0, prev_req = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0, p_wd = '0;
  logic [15:0] rd, erd, ra, rdat;
  logic h, eh, rwe;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < 16; s++) cnt[s] = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = bmem[i];
  endtask
  task automatic model(input logic we, input logic [15:0] a, input logic [15:0] d, output logic [15:0] exp_rd, output logic exp_hit);
    int s, t;
    s = int'(a[5:2]);
    t = int'(a[15:6]);
    exp_hit = 1'b0;
    if (cnt[s] > 0 && rec[s][cnt[s]-1] == t) exp_hit = 1'b1;
    else if (cnt[s] == 2 && rec[s][0] == t) begin
      exp_hit = 1'b1;
      rec[s][0] = rec[s][1];
      rec[s][1] = t;
    end else if (cnt[s] < 2) begin
      rec[s][cnt[s]] = t;
      cnt[s]++;
    end else begin
      rec[s][0] = rec[s][1];
      rec[s][1] = t;
    end
    exp_rd = ref_mem[a];
    if (we) ref_mem[a] = d;
  endtask
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d, output logic [15:0] r, output logic hh);
    int cyc = 0;
    beats.delete();
    bursts = 0;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!cpu_ready && cyc < 400);
    check("cpu_ready", cpu_ready, 1);
    r = cpu_rdata;
    hh = cpu_hit;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
        pend = 1'b0;
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) bursts++;
        if (mem_req && pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd)) stable_err++;
        if (mem_req && wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          beats.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = bmem[mem_addr];
        end else if (mem_req) wait_cnt++;
        else wait_cnt = 0;
        pend = mem_req && !mem_ack;
        prev_req = mem_req;
        p_addr = mem_addr;
        p_we = mem_we;
        p_wd = mem_wdata;
      end
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [15:0] ea;
    vt[0] = '{1'b0, 16'h0009, 16'h0000, 16'hA5AC, 1'b0, 0, 4, 1, 16'h0000, 16'h0008};
    vt[1] = '{1'b0, 16'h0009, 16'h0000, 16'hA5AC, 1'b1, 0, 0, 0, 16'h0000, 16'h0000};
    vt[2] = '{1'b1, 16'h0009, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 16'h0000, 16'h0000};
    vt[3] = '{1'b0, 16'h0009, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 16'h0000, 16'h0000};
    vt[4] = '{1'b0, 16'h0049, 16'h0000, 16'hA5EC, 1'b0, 0, 4, 1, 16'h0000, 16'h0048};
    vt[5] = '{1'b0, 16'h0089, 16'h0000, 16'hA52C, 1'b0, 4, 4, 2, 16'h0008, 16'h0088};
    vt[6] = '{1'b0, 16'h0049, 16'h0000, 16'hA5EC, 1'b1, 0, 0, 0, 16'h0000, 16'h0000};
    for (int i = 0; i < 65536; i++) bmem[i] = 16'(i) ^ 16'hA5A5;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst cpu_ready", cpu_ready, 0);
    check("rst cpu_hit", cpu_hit, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      model(vt[i].we, vt[i].addr, vt[i].wdata, erd, eh);
      access(vt[i].we, vt[i].addr, vt[i].wdata, rd, h);
      if (!vt[i].we) check("vec rdata", rd, vt[i].rdata);
      check("vec hit", h, vt[i].hit);
      check("vec beats", beats.size(), vt[i].nwb + vt[i].nfill);
      check("vec bursts", bursts, vt[i].nbursts);
      for (int b = 0; b < beats.size() && b < vt[i].nwb + vt[i].nfill; b++) begin
        ea = (b < vt[i].nwb ? vt[i].wb_base : vt[i].fill_base) + 16'(b % 4);
        check("beat we", beats[b].we, b < vt[i].nwb);
        check("beat addr", beats[b].addr, ea);
        if (b < vt[i].nwb) check("wb data", beats[b].data, ref_mem[ea]);
      end
    end
    ack_delay = 3;
    model(1'b0, 16'h00C5, 16'h0000, erd, eh);
    access(1'b0, 16'h00C5, 16'h0000, rd, h);
    check("stall rdata", rd, 16'hA560);
    check("stall hit", h, 0);
    check("stall beats", beats.size(), 4);
    check("stall bursts", bursts, 1);
    check("stall stable", stable_err, 0);
    ack_delay = 1;
    beats.delete();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0105;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (beats.size() < 1 && n < 100);
    check("rst first beat", beats.size(), 1);
    @(posedge clk);
    #3;
    check("pre-rst mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("midrst mem_req", mem_req, 0);
    check("midrst cpu_ready", cpu_ready, 0);
    check("midrst mem_addr", mem_addr, 0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    model(1'b0, 16'h0009, 16'h0000, erd, eh);
    access(1'b0, 16'h0009, 16'h0000, rd, h);
    check("postrst hit", h, 0);
    check("postrst rdata", rd, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      rwe = $urandom_range(0, 9) < 4;
      ra = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      rdat = 16'($urandom);
      ack_delay = $urandom_range(0, 2);
      model(rwe, ra, rdat, erd, eh);
      access(rwe, ra, rdat, rd, h);
      if (!rwe) check("rand rdata", rd, erd);
      check("rand hit", h, eh);
    end
    check("final stable", stable_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
